// File: rtl/maze_pkg.sv
// Shared constants, state encoding and helpers for the maze generator.
package maze_pkg;

  localparam int          MAX_NUM      = 19;
  localparam int          MAP_W        = MAX_NUM * MAX_NUM;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [4:0]  MIN_SIDE     = 5'd5;
  localparam logic [4:0]  MAX_SIDE     = 5'd19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    CARVE  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Clamp the requested side into [5,19] and force it odd so every
  // carved cell sits on odd coordinates inside a wall border.
  function automatic logic [4:0] legalise_num(input logic [4:0] n);
    if (n < MIN_SIDE) return MIN_SIDE;
    if (n > MAX_SIDE) return MAX_SIDE;
    if (!n[0])        return n - 5'd1;
    return n;
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Galois LFSR supplying the north/west choice for each carved cell.
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_sys_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // A zero seed would lock the LFSR, so it is replaced by the default.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      q_q <= DEFAULT_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/maze_gen.sv
// Binary-tree maze carver: clears the map, then visits one odd cell per
// clock, opening it and (except at the start cell) one wall toward the
// north or west neighbour.
module maze_gen
  import maze_pkg::*;
(
  input  logic             clk,
  input  logic             rst_sys_n,
  input  logic             start,
  input  logic [4:0]       num,
  input  logic [15:0]      seed,
  output logic [MAP_W-1:0] map,
  output logic [4:0]       num_q,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [4:0]       side_q;
  logic [4:0]       cx_q;
  logic [4:0]       cy_q;
  logic [MAP_W-1:0] map_q;
  logic             busy_q;
  logic             done_q;

  logic [15:0]      lfsr_q;
  logic             lfsr_load;
  logic             lfsr_step;

  logic [8:0]       side9;
  logic [8:0]       cx9;
  logic [8:0]       cy9;
  logic [8:0]       idx_cell;
  logic [8:0]       idx_north;
  logic [8:0]       idx_west;
  logic [8:0]       idx_carve;
  logic             row_end;
  logic             last_cell;
  logic             carve_en;
  logic             go_north;

  assign lfsr_load = (state_q == IDLE) && start;
  assign lfsr_step = (state_q == CARVE);

  maze_lfsr u_lfsr (
    .clk       (clk),
    .rst_sys_n (rst_sys_n),
    .load      (lfsr_load),
    .seed      (seed),
    .step      (lfsr_step),
    .q         (lfsr_q)
  );

  // Cell address and carve direction; 9-bit arithmetic covers index 360.
  always_comb begin
    side9     = {4'd0, side_q};
    cx9       = {4'd0, cx_q};
    cy9       = {4'd0, cy_q};
    idx_cell  = cy9 * side9 + cx9;
    idx_north = idx_cell - side9;
    idx_west  = idx_cell - 9'd1;
    row_end   = (cx_q == side_q - 5'd2);
    last_cell = row_end && (cy_q == side_q - 5'd2);
    carve_en  = !((cx_q == 5'd1) && (cy_q == 5'd1));
    // Top row can only go west, left column can only go north.
    if (cy_q == 5'd1) begin
      go_north = 1'b0;
    end else if (cx_q == 5'd1) begin
      go_north = 1'b1;
    end else begin
      go_north = lfsr_q[0];
    end
    idx_carve = go_north ? idx_north : idx_west;
  end

  // Control FSM, cell scan counters and map storage.
  always_ff @(posedge clk) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      side_q  <= MIN_SIDE;
      cx_q    <= 5'd1;
      cy_q    <= 5'd1;
      map_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            side_q  <= legalise_num(num);
            cx_q    <= 5'd1;
            cy_q    <= 5'd1;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          map_q   <= '0;
          state_q <= CARVE;
        end
        CARVE: begin
          map_q[idx_cell] <= 1'b1;
          if (carve_en) begin
            map_q[idx_carve] <= 1'b1;
          end
          if (last_cell) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (row_end) begin
            cx_q <= 5'd1;
            cy_q <= cy_q + 5'd2;
          end else begin
            cx_q <= cx_q + 5'd2;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign map   = map_q;
  assign num_q = side_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
